// File: rtl/my_bitscan16.sv
// my_bitscan16: sequential set-bit scanner.
// Accepts one 16-bit word, then emits the 4-bit index of each set bit,
// lowest first, one index per beat on a valid/ready output stream.
// Optional feature macro: MY_BITSCAN16_POPCOUNT_EN adds the popcnt port,
// which reports the set-bit count of the last accepted word.
//
// Handshake semantics (both streams): a transfer happens on a rising clk
// edge where valid and ready are both 1. A producer holds valid and its
// payload stable until the transfer; valid never depends on ready.
// The state register is visible as busy (SCAN) / in_ready (IDLE).
module my_bitscan16 (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        any
`ifdef MY_BITSCAN16_POPCOUNT_EN
    ,
    output logic [4:0]  popcnt
`endif
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_SCAN = 1'b1;

    logic        state;
    logic [15:0] pend;
    logic [3:0]  low_idx;
    logic        pend_single;
    logic        accept;
    logic        beat;

    assign accept = in_valid && (state == ST_IDLE);
    assign beat   = out_ready && (state == ST_SCAN);

    // Lowest set bit of pend; scanning from the top lets lower bits win.
    always_comb begin
        low_idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend[i]) begin
                low_idx = 4'(i);
            end
        end
    end

    // Exactly one bit left: clearing the lowest set bit leaves zero.
    assign pend_single = (pend != 16'd0) && ((pend & (pend - 16'd1)) == 16'd0);

    // Outputs decode only state and pend, so no input reaches an output
    // combinationally.
    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_SCAN);
    assign out_valid = (state == ST_SCAN);
    assign out_idx   = low_idx;
    assign out_last  = (state == ST_SCAN) && pend_single;

    // Scanner state, pending bits and the any flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            pend  <= 16'd0;
            any   <= 1'b0;
        end else begin
            if (accept) begin
                any <= |in;
                // A zero word produces no beats, so the block stays idle.
                if (in != 16'd0) begin
                    pend  <= in;
                    state <= ST_SCAN;
                end
            end else if (beat) begin
                if (pend_single) begin
                    pend  <= 16'd0;
                    state <= ST_IDLE;
                end else begin
                    // Drop the lowest set bit just emitted.
                    pend <= pend & (pend - 16'd1);
                end
            end
        end
    end

`ifdef MY_BITSCAN16_POPCOUNT_EN
    logic [4:0] in_ones;

    // Set-bit count of the offered word.
    always_comb begin
        in_ones = 5'd0;
        for (int i = 0; i < 16; i++) begin
            in_ones = in_ones + {4'd0, in[i]};
        end
    end

    // Capture the count on accept; it holds until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            popcnt <= 5'd0;
        end else if (accept) begin
            popcnt <= in_ones;
        end
    end
`endif

endmodule
